rmii_tx: RTL
============

# rmii_tx

Transmit-side Ethernet MAC datapath for the RMII interface, sitting between a byte FIFO (user side) and the PHY on REF_CLK. It pops one frame's bytes (header, body, FCS already present) from the FIFO, prepends the preamble and SFD, and serialises the frame as dibits. It then enforces the inter-packet gap. Gray-coded 16-bit monitor counters report completed frames and FIFO underruns.

## Interface
- No parameters.
- REF_CLK  in  1  50 MHz RMII reference clock; the only clock.
- arst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  8  FIFO read data; valid the cycle after fifo_rden.
- fifo_EOD_out  in  1  end-of-data tag of the byte on fifo_dout (last FCS byte).
- fifo_rden  out  1  FIFO read strobe, one cycle per byte.
- TX_EN  out  1  RMII transmit enable.
- TXD0, TXD1  out  1 each  RMII transmit dibit.
- succ_tx_count_gray  out  16  frames completed, gray code.
- underrun_count_gray  out  16  frames aborted on FIFO empty, gray code.

## Operation
- All outputs are registered. Reset values: TX_EN=0, TXD0=0, TXD1=0, fifo_rden=0, both counters 0, state S_IDLE.
- Bytes are sent LSB dibit first: {TXD1,TXD0} = byte[1:0], [3:2], [5:4], [7:6]. Each byte takes 4 cycles, tracked by a 2-bit counter.
- S_IDLE: TX_EN=0, TXD=00. When fifo_empty=0, go to S_PREAMBLE with the counter cleared.
- S_PREAMBLE: 32 cycles with TX_EN=1.
  - Cycles 0–30: {TXD1,TXD0}=01.
  - Cycle 31: 11 (7×0x55 then 0xD5).
  - fifo_rden pulses in cycle 29; the byte is captured in cycle 30 into the shift register, together with its EOD tag.
  - After cycle 31, go to S_DATA.
- S_DATA: shift out the held byte.
  - In dibit slot 1, if the current byte's EOD=0: pulse fifo_rden if fifo_empty=0. The next byte is captured in slot 2 and loaded at the slot-3→0 boundary.
  - If fifo_empty=1 at slot 1 with EOD=0, this is an underrun. Finish the current byte, then force TX_EN=0, increment underrun_count, and go to S_DRAIN.
  - If the current byte has EOD=1, go to S_IFG after slot 3 and increment succ_tx_count.
- S_DRAIN: TX_EN=0. Pop bytes (one rden per 2 cycles, empty permitting) until a byte with EOD=1 is read, then go to S_IFG.
- S_IFG: TX_EN=0 and TXD=00 for 48 cycles (96 bit times), then go to S_IDLE.
- An illegal state goes to S_IFG.
- Counters wrap at 0xFFFF→0. Gray conversion is combinational from the binary registers.
- Asserting arst_n low mid-frame drops TX_EN immediately (async) and counts nothing. After release, operation starts in S_IDLE. Bytes left in the FIFO are treated as a new frame; the user side flushes the FIFO on reset.

## Timing
- Start latency: fifo_empty falls in cycle N → TX_EN=1 with the first preamble dibit in cycle N+2 (state register, then output register).
- First data dibit appears 32 cycles after the first preamble dibit.
- A frame of L bytes occupies TX_EN for exactly 32+4L cycles. It is followed by at least 48 TX_EN=0 cycles before the next preamble.
- fifo_rden is a single-cycle pulse, at most once per 4 cycles in S_DATA.
- Underrun: TX_EN falls at the byte boundary after the failed slot-1 check. A partial frame is therefore always a whole number of bytes.
- fifo_empty rising simultaneously with a capture cycle has no effect. Only the slot-1 sample decides.
- An EOD byte with fifo_empty=0 issues no further rden. The next frame starts only via S_IFG→S_IDLE.

## Structure
- Shared package `rmii_pkg`: state encodings (S_IDLE, S_PREAMBLE, S_DATA, S_IFG, S_DRAIN), PREAMBLE_CYCLES=32, IFG_CYCLES=48, SFD=8'hD5, PREAMBLE_BYTE=8'h55.
- Reuse the existing `my_bin2gray` (WIDTH=16) twice for the monitor outputs. There is no other sub-module; the FSM, shift register and counters stay in one file.

## Test plan
- Single 4-byte frame {0x12,0x34,0x56,0x78(EOD)} preloaded → TXD sequence shows 31×01, then 11, then 10,00,01,00 for 0x12; TX_EN high for exactly 48 cycles; succ_tx_count_gray=0x0001.
- Two 1-byte frames back-to-back in the FIFO → the second preamble starts ≥48 cycles after the first TX_EN falls; counter=0x0003 (gray of 2).
- FIFO empties after the 2nd byte of a frame without EOD → TX_EN falls after byte 2; underrun_count_gray=0x0001. The rest of the frame written later is drained until EOD, and transmission of the next frame is correct.
- arst_n pulsed low during the data phase → all outputs 0 within the same cycle; after release state is S_IDLE and counters are 0.
- Force succ_tx_count=0xFFFF, send one frame → count wraps to 0x0000; gray output is 0x0000.
- fifo_rden audit over a 64-byte frame → exactly 64 pulses, never 2 within 4 cycles, none after EOD.

Source files
------------

// File: rtl/rmii_pkg.sv
// rmii_pkg -- shared definitions for the RMII transmit datapath.
//   state_t          : FSM state encoding
//   PREAMBLE_CYCLES  : dibit cycles of preamble + SFD
//   IFG_CYCLES       : dibit cycles of enforced inter-packet gap
//   preamble_dibit() : dibit to drive in a given preamble cycle
package rmii_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREAMBLE = 3'd1,
      S_DATA     = 3'd2,
      S_IFG      = 3'd3,
      S_DRAIN    = 3'd4
   } state_t;

   localparam int         PREAMBLE_CYCLES = 32;
   localparam int         IFG_CYCLES      = 48;
   localparam logic [7:0] SFD             = 8'hD5;
   localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;

   // Preamble is 7 x 0x55 then 0xD5, sent LSB dibit first like any byte.
   function automatic logic [1:0] preamble_dibit(input logic [4:0] idx);
      logic [7:0] w_byte;
      w_byte = (idx < 5'(PREAMBLE_CYCLES - 4)) ? PREAMBLE_BYTE : SFD;
      return w_byte[{idx[1:0], 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/my_bin2gray.sv
// my_bin2gray -- combinational binary to gray code converter.
//   i_bin  : binary input, WIDTH bits
//   o_gray : gray-coded output, WIDTH bits
module my_bin2gray #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_bin,
   output logic [WIDTH-1:0] o_gray
);

   assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/rmii_tx.sv
// rmii_tx -- RMII transmit MAC datapath.
// Pops one frame (header, body, FCS) from a byte FIFO, prepends preamble/SFD,
// serialises LSB dibit first on TXD1/TXD0 and enforces the inter-packet gap.
//   REF_CLK             : 50 MHz RMII reference clock
//   arst_n              : asynchronous active-low reset
//   fifo_empty          : FIFO empty flag
//   fifo_dout           : FIFO read data, valid the cycle after fifo_rden
//   fifo_EOD_out        : end-of-frame tag for fifo_dout
//   fifo_rden           : FIFO read strobe, one cycle per byte
//   TX_EN, TXD0, TXD1   : RMII transmit outputs
//   succ_tx_count_gray  : completed frames, gray code
//   underrun_count_gray : frames aborted on FIFO underrun, gray code
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | line quiet, waiting for FIFO to become non-empty
// S_PREAMBLE | 31 x 01 dibits then 11 (SFD); first byte fetched meanwhile
// S_DATA     | shifting out held byte; next byte fetched in slot 1
// S_DRAIN    | after underrun, discard bytes up to and including EOD
// S_IFG      | 48 quiet cycles before the next frame may start
module rmii_tx
   import rmii_pkg::*;
(
   input  logic        REF_CLK,
   input  logic        arst_n,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_dout,
   input  logic        fifo_EOD_out,
   output logic        fifo_rden,
   output logic        TX_EN,
   output logic        TXD0,
   output logic        TXD1,
   output logic [15:0] succ_tx_count_gray,
   output logic [15:0] underrun_count_gray
);

   // Outputs are registered from the state, so an action placed at counter
   // value k becomes visible on the pins one cycle later.
   localparam logic [5:0] C_PRE_RDEN = 6'(PREAMBLE_CYCLES - 4);
   localparam logic [5:0] C_PRE_CAPT = 6'(PREAMBLE_CYCLES - 2);
   localparam logic [5:0] C_PRE_LAST = 6'(PREAMBLE_CYCLES - 1);
   localparam logic [5:0] C_IFG_LAST = 6'(IFG_CYCLES - 1);

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [7:0]  r_shift;
   logic        r_eod;
   logic        r_underrun;
   logic        r_dvalid;
   logic        r_rden;
   logic        r_tx_en;
   logic [1:0]  r_txd;
   logic        r_succ_inc;
   logic        r_undr_inc;
   logic [15:0] r_succ_cnt;
   logic [15:0] r_undr_cnt;
   logic [1:0]  w_slot;

   assign w_slot    = r_cnt[1:0];
   assign fifo_rden = r_rden;
   assign TX_EN     = r_tx_en;
   assign TXD1      = r_txd[1];
   assign TXD0      = r_txd[0];

   always_ff @(posedge REF_CLK or negedge arst_n) begin
      if (!arst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_eod      <= 1'b0;
         r_underrun <= 1'b0;
         r_dvalid   <= 1'b0;
         r_rden     <= 1'b0;
         r_tx_en    <= 1'b0;
         r_txd      <= 2'b00;
         r_succ_inc <= 1'b0;
         r_undr_inc <= 1'b0;
      end else begin
         r_rden     <= 1'b0;
         r_succ_inc <= 1'b0;
         r_undr_inc <= 1'b0;
         r_dvalid   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx_en    <= 1'b0;
               r_txd      <= 2'b00;
               r_cnt      <= '0;
               r_underrun <= 1'b0;
               if (!fifo_empty) begin
                  r_state <= S_PREAMBLE;
               end
            end

            S_PREAMBLE: begin
               r_tx_en <= 1'b1;
               r_txd   <= preamble_dibit(r_cnt[4:0]);
               // FIFO was non-empty on entry, so the first byte is present.
               if (r_cnt == C_PRE_RDEN) begin
                  r_rden <= 1'b1;
               end
               if (r_cnt == C_PRE_CAPT) begin
                  r_shift <= fifo_dout;
                  r_eod   <= fifo_EOD_out;
               end
               if (r_cnt == C_PRE_LAST) begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end

            S_DATA: begin
               r_tx_en <= 1'b1;
               r_txd   <= r_shift[{w_slot, 1'b0} +: 2];
               r_cnt   <= {4'd0, w_slot + 2'd1};
               // Only the slot-1 empty sample decides between fetch and underrun.
               if (w_slot == 2'd1 && !r_eod) begin
                  if (!fifo_empty) begin
                     r_rden <= 1'b1;
                  end else begin
                     r_underrun <= 1'b1;
                  end
               end
               if (w_slot == 2'd3) begin
                  if (r_eod) begin
                     r_state    <= S_IFG;
                     r_cnt      <= '0;
                     r_succ_inc <= 1'b1;
                  end else if (r_underrun) begin
                     r_state    <= S_DRAIN;
                     r_cnt      <= '0;
                     r_underrun <= 1'b0;
                     r_undr_inc <= 1'b1;
                  end else begin
                     // Byte fetched in slot 1 is on fifo_dout now.
                     r_shift <= fifo_dout;
                     r_eod   <= fifo_EOD_out;
                  end
               end
            end

            S_DRAIN: begin
               r_tx_en  <= 1'b0;
               r_txd    <= 2'b00;
               // r_dvalid marks the cycle in which a popped byte is on fifo_dout.
               r_dvalid <= r_rden;
               if (r_dvalid && fifo_EOD_out) begin
                  r_state  <= S_IFG;
                  r_cnt    <= '0;
                  r_dvalid <= 1'b0;
               end else if (!r_rden && !fifo_empty) begin
                  r_rden <= 1'b1;
               end
            end

            S_IFG: begin
               r_tx_en <= 1'b0;
               r_txd   <= 2'b00;
               if (r_cnt == C_IFG_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end

            default: begin
               r_state <= S_IFG;
               r_cnt   <= '0;
               r_tx_en <= 1'b0;
               r_txd   <= 2'b00;
            end
         endcase
      end
   end

   // Counters are rewritten every cycle so their value always follows the
   // register contents plus the pending increment.
   always_ff @(posedge REF_CLK or negedge arst_n) begin
      if (!arst_n) begin
         r_succ_cnt <= '0;
         r_undr_cnt <= '0;
      end else begin
         r_succ_cnt <= r_succ_cnt + {15'd0, r_succ_inc};
         r_undr_cnt <= r_undr_cnt + {15'd0, r_undr_inc};
      end
   end

   my_bin2gray #(.WIDTH(16)) u_succ_gray (
      .i_bin  (r_succ_cnt),
      .o_gray (succ_tx_count_gray)
   );

   my_bin2gray #(.WIDTH(16)) u_undr_gray (
      .i_bin  (r_undr_cnt),
      .o_gray (underrun_count_gray)
   );

endmodule
